// File: rtl/ps2_pkg.sv
// Shared types and error codes for the PS/2 keyboard receiver.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a debounce filter: the output follows the
// input only after FILTER_LEN consecutive samples that disagree with it.
`timescale 1ns/1ps
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A one-bit line has only one value differing from out_q, so counting
  // disagreeing samples is the same as counting identical new samples.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (sync2_q != out_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      out_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: filters KCLK/KDAT, deframes 11-bit frames and
// reports good bytes, parity/framing errors and inter-edge timeouts.
`timescale 1ns/1ps
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input  logic       CLK_50,
  input  logic       RESET,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  logic kclk_f, kdat_f;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk (CLK_50),
    .srst(RESET),
    .din (ps2_clk),
    .dout(kclk_f)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk (CLK_50),
    .srst(RESET),
    .din (ps2_dat),
    .dout(kdat_f)
  );

  state_t          state_q, state_d;
  logic            kclk_prev_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_err_q, par_err_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            sample;
  logic            to_hit;

  assign sample = kclk_prev_q & ~kclk_f;
  assign to_hit = (to_cnt_q == TW'(TO_LIMIT));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_code_d = err_code_q;
    to_cnt_d   = (state_q == IDLE || sample) ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (sample && !kdat_f) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {kdat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample) begin
          par_err_d = ~(^{shift_q, kdat_f});
          state_d   = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          if (par_err_q) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_PARITY;
          end else if (!kdat_f) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_FRAME;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A sample event in the terminal cycle keeps the frame alive.
    if (state_q != IDLE && !sample && to_hit) begin
      state_d    = IDLE;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q     <= IDLE;
      kclk_prev_q <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      to_cnt_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      kclk_prev_q <= kclk_f;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      to_cnt_q    <= to_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign err_code = err_code_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter TIMEOUT_US, default 200, maximum gap between keyboard clock edges inside a frame, in microseconds.
REQ-003 The block SHALL have parameter FILTER_LEN, default 8, number of consecutive equal samples required before a filtered line changes.
REQ-004 The block SHALL have port CLK_50, input, 1 bit, system clock; it is the single clock of the block.
REQ-005 The block SHALL have port RESET, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port ps2_clk, input, 1 bit, asynchronous keyboard clock (KCLK).
REQ-007 The block SHALL have port ps2_dat, input, 1 bit, asynchronous keyboard data (KDAT).
REQ-008 The block SHALL have port rx_data, output, 8 bits, last correctly received scan-code byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit, one-cycle pulse marking an update of rx_data.
REQ-010 The block SHALL have port rx_err, output, 1 bit, one-cycle pulse marking an aborted frame.
REQ-011 The block SHALL have port err_code, output, 2 bits, cause of the last error: 01 parity, 10 framing, 11 timeout.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.

Function
REQ-013 Each of ps2_clk and ps2_dat SHALL pass through a 2-FF synchronizer, then a filter whose output changes only after FILTER_LEN consecutive identical synchronized samples.
REQ-014 A sample event SHALL be a 1-to-0 transition of the filtered clock; filtered data is sampled in the same cycle.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE, a sample event with data=0 (start bit) SHALL move the FSM to DATA with the bit count cleared.
REQ-017 In IDLE, a sample event with data=1 SHALL be ignored.
REQ-018 DATA SHALL shift in 8 bits LSB first, then move to PARITY.
REQ-019 PARITY SHALL check odd parity over the 8 data bits plus the parity bit; a mismatch is latched but the FSM still moves to STOP.
REQ-020 The STOP sample SHALL return the FSM to IDLE and act on the frame result as follows.
REQ-021 On a good frame (stop=1 and parity OK), the STOP sample SHALL load rx_data and pulse rx_valid for exactly 1 cycle, in the cycle after the sample event.
REQ-022 On a parity error, the STOP sample SHALL pulse rx_err and set err_code=01.
REQ-023 On a framing error (stop=0 with parity OK), the STOP sample SHALL pulse rx_err and set err_code=10.
REQ-024 When both parity and stop bit are bad, the parity error SHALL take precedence (err_code=01).
REQ-025 rx_data SHALL hold its value on any error.
REQ-026 A timeout counter of width ceil(log2(CLK_HZ/1e6*TIMEOUT_US+1)) SHALL clear on every sample event and in IDLE, and increment otherwise.
REQ-027 When the timeout counter reaches CLK_HZ/1000000*TIMEOUT_US in a non-IDLE state, the block SHALL pulse rx_err, set err_code=11, and return to IDLE.
REQ-028 When a sample event and the timeout terminal count occur in the same cycle, the sample event SHALL win and no timeout is raised.
REQ-029 rx_valid and rx_err SHALL never be high in the same cycle.
REQ-030 busy SHALL equal (state != IDLE).
REQ-031 err_code SHALL hold its value until the next error.

Reset
REQ-032 While RESET is high at a CLK_50 edge, the FSM SHALL go to IDLE, and all counters and the shift register SHALL clear.
REQ-033 Reset values SHALL be rx_data=0x00, rx_valid=0, rx_err=0, err_code=00, busy=0.
REQ-034 Filter outputs SHALL reset to 1 (idle bus).
REQ-035 A reset asserted mid-frame SHALL discard the partial frame without an error pulse; reception restarts at the next start bit.

Structure
REQ-036 A shared package ps2_pkg SHALL hold the FSM state enum and the constants ERR_PARITY=2'b01, ERR_FRAME=2'b10 and ERR_TIMEOUT=2'b11.
REQ-037 Synchronizer plus filter SHALL be a sub-module ps2_filter (parameter FILTER_LEN), instantiated twice.

Verification
REQ-038 The bench SHALL drive 0x1C with parity=0, stop=1 at 12.5 kHz bit rate -> one rx_valid pulse, rx_data=0x1C, rx_err never high.
REQ-039 The bench SHALL drive 0xF0 (parity=1) followed by 0x1C -> two rx_valid pulses with rx_data 0xF0 then 0x1C; busy is low between frames.
REQ-040 The bench SHALL drive 0x1C with parity=1 -> rx_err pulse, err_code=01, rx_data unchanged; then send 0x1C with stop=0 -> rx_err pulse, err_code=10.
REQ-041 The bench SHALL drive a start bit plus 4 data bits, then hold the clock high for 250 us -> rx_err with err_code=11 about 200 us after the last edge; a following good 0x5A frame yields rx_valid with rx_data=0x5A.
REQ-042 The bench SHALL inject a 3-cycle low glitch on ps2_clk during a 0x1C frame -> the glitch is ignored and 0x1C is received correctly.
REQ-043 The bench SHALL assert RESET for 1 cycle after the 5th bit of a frame -> busy=0 next cycle, no rx_valid or rx_err pulse, and the next full frame is received correctly.
